// File: rtl/cpu_defs.sv
// Definitions shared between the CPU-side blocks: default word width and the
// state encoding of the memory dump reader.
package cpu_defs;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRead    = 3'd1,
    StCapture = 3'd2,
    StSend    = 3'd3,
    StDone    = 3'd4
  } dump_state_e;

endpackage

// File: rtl/dump_out_reg.sv
// Output holding register for the dump stream: loads one word and keeps it
// stable until the consumer takes it.
module dump_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [31:0]           load_addr,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           out_addr,
  output logic                  out_last
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [31:0]           addr_q;
  logic                  last_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
      addr_q  <= load_addr;
      last_q  <= load_last;
    end else if (valid_q && out_ready) begin
      // Payload is left in place after the handshake; only valid drops.
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;

endmodule

// File: rtl/mem_dump_reader.sv
// Walks a word-aligned range of data memory through a secondary read port,
// streams each word out over valid/ready and accumulates an XOR checksum.
module mem_dump_reader
  import cpu_defs::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int unsigned COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   mem_rd_en,
  output logic [31:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [31:0]            out_addr,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  checksum
);

  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  dump_state_e            state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0]  checksum_q, checksum_d;
  logic                   load;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^base_addr[1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    checksum_d  = checksum_q;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          checksum_d = '0;
          if (word_count != '0) begin
            addr_d      = {base_addr[31:2], 2'b00};
            remaining_d = word_count;
            state_d     = StRead;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (out_valid && out_ready) begin
          checksum_d = checksum_q ^ out_data;
          if (remaining_q == CountOne) begin
            state_d = StDone;
          end else begin
            remaining_d = remaining_q - CountOne;
            addr_d      = addr_q + 32'd4;
            state_d     = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // addr_q only moves on start or handshake, so the port holds its last value.
  assign mem_rd_en = (state_q == StRead);
  assign mem_addr  = addr_q;
  assign busy      = (state_q == StRead) || (state_q == StCapture) || (state_q == StSend);
  assign done      = (state_q == StDone);
  assign checksum  = checksum_q;

  dump_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_data(mem_rd_data),
    .load_addr(addr_q),
    .load_last(remaining_q == CountOne),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
  );

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a small memory model and a
// scoreboard of expected stream words.
module tb_mem_dump_reader;

  localparam int DW = 32;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          mem_rd_en;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [31:0]   out_addr;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;

  mem_dump_reader #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr[7:2]];
  end

  typedef struct packed {
    logic [31:0]   addr;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: every valid word must match the scoreboard head.
  always @(negedge clk) begin
    if (mem_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        check("out_addr", 64'(out_addr), 64'(sb[0].addr));
        check("out_data", 64'(out_data), 64'(sb[0].data));
        check("out_last", 64'(out_last), 64'(sb[0].last));
        if (out_ready) begin
          void'(sb.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [31:0] base, input int n);
    logic [31:0] a;
    exp_t e;
    a = {base[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      e.addr = a;
      e.data = mem[a[7:2]];
      e.last = (i == n - 1);
      sb.push_back(e);
      a = a + 32'd4;
    end
  endtask

  function automatic logic [DW-1:0] exp_chk(input logic [31:0] base, input int n);
    logic [31:0] a;
    logic [DW-1:0] x;
    a = {base[31:2], 2'b00};
    x = '0;
    for (int i = 0; i < n; i++) begin
      x = x ^ mem[a[7:2]];
      a = a + 32'd4;
    end
    return x;
  endfunction

  task automatic pulse_start(input logic [31:0] base, input int n);
    base_addr  = base;
    word_count = CW'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_hs(input int target, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hs_cnt >= target) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int lat, rd0, d0, h0;

    for (int i = 0; i < 64; i++) mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h44;
    mem[3] = 32'h88;

    out_ready = 1'b1;
    tick(); tick(); tick();
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_addr", 64'(out_addr), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_checksum", 64'(checksum), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: basic dump with latency
    push_dump(32'h0, 4);
    rd0 = rd_cnt; d0 = done_cnt;
    pulse_start(32'h0, 4);
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("first_valid_latency", 64'(lat), 64'd3);
    wait_done(40, seen);
    check("t1_done_seen", 64'(seen), 64'd1);
    check("t1_checksum", 64'(checksum), 64'hFF);
    check("t1_busy_in_done", 64'(busy), 64'd0);
    tick();
    check("t1_done_one_cycle", 64'(done), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_reads", 64'(rd_cnt - rd0), 64'd4);
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);

    // 2: back-pressure on word 2
    push_dump(32'h0, 4);
    h0 = hs_cnt;
    pulse_start(32'h0, 4);
    wait_hs(h0 + 1, 20, seen);
    check("t2_first_hs", 64'(seen), 64'd1);
    out_ready = 1'b0;
    wait_valid(10, seen);
    check("t2_word2_valid", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("t2_held_valid", 64'(out_valid), 64'd1);
    check("t2_no_hs_while_stalled", 64'(hs_cnt - h0), 64'd1);
    out_ready = 1'b1;
    wait_done(40, seen);
    check("t2_done_seen", 64'(seen), 64'd1);
    check("t2_checksum", 64'(checksum), 64'hFF);
    check("t2_words", 64'(hs_cnt - h0), 64'd4);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // 3: zero-length dump
    rd0 = rd_cnt;
    pulse_start(32'h40, 0);
    check("t3_done", 64'(done), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_checksum", 64'(checksum), 64'd0);
    tick();
    check("t3_done_one_cycle", 64'(done), 64'd0);
    check("t3_no_reads", 64'(rd_cnt - rd0), 64'd0);

    // 4: misaligned base
    push_dump(32'h13, 2);
    pulse_start(32'h13, 2);
    wait_done(40, seen);
    check("t4_done_seen", 64'(seen), 64'd1);
    check("t4_checksum", 64'(checksum), 64'(exp_chk(32'h13, 2)));
    check("t4_mem_addr_hold", 64'(mem_addr), 64'h14);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // 5: address wrap
    push_dump(32'hFFFF_FFFC, 2);
    pulse_start(32'hFFFF_FFFC, 2);
    wait_done(40, seen);
    check("t5_done_seen", 64'(seen), 64'd1);
    check("t5_checksum", 64'(checksum), 64'(exp_chk(32'hFFFF_FFFC, 2)));
    check("t5_mem_addr_wrap", 64'(mem_addr), 64'h0);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);
    tick();

    // 6: reset during SEND of word 2, then a clean dump with an ignored start
    push_dump(32'h0, 4);
    h0 = hs_cnt;
    pulse_start(32'h0, 4);
    wait_hs(h0 + 1, 20, seen);
    check("t6_first_hs", 64'(seen), 64'd1);
    out_ready = 1'b0;
    wait_valid(10, seen);
    check("t6_word2_valid", 64'(seen), 64'd1);
    d0 = done_cnt;
    reset_n = 1'b0;
    tick();
    sb.delete();
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_out_data", 64'(out_data), 64'd0);
    check("t6_rst_out_addr", 64'(out_addr), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_checksum", 64'(checksum), 64'd0);
    check("t6_rst_mem_addr", 64'(mem_addr), 64'd0);
    check("t6_rst_rd_en", 64'(mem_rd_en), 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("t6_no_done_on_reset", 64'(done_cnt - d0), 64'd0);

    push_dump(32'h20, 4);
    rd0 = rd_cnt; d0 = done_cnt; h0 = hs_cnt;
    pulse_start(32'h20, 4);
    tick(); tick();
    base_addr  = 32'h0;
    word_count = CW'(1);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_done(40, seen);
    check("t6_done_seen", 64'(seen), 64'd1);
    check("t6_checksum", 64'(checksum), 64'(exp_chk(32'h20, 4)));
    tick(); tick(); tick(); tick();
    check("t6_idle_after", 64'(busy), 64'd0);
    check("t6_words", 64'(hs_cnt - h0), 64'd4);
    check("t6_reads", 64'(rd_cnt - rd0), 64'd4);
    check("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t6_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
